// File: rtl/sram_arbiter_if.sv
// SRAM-like request/response channel.
// A requester drives req/wr/size/wstrb/addr/wdata and receives addr_ok (request
// accepted), data_ok (response returned) and rdata. The "master" modport is the
// side that issues requests; "slave" is the side that accepts them.
interface sram_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester arbiter onto one shared SRAM-like channel.
// The data requester has fixed priority over the instruction requester. A grant
// that has been presented downstream but not yet accepted is locked until it is
// accepted or withdrawn. A small owner FIFO records who each accepted
// transaction belongs to, so in-order responses are steered back to the right
// requester with no added latency.
// Ports:
//   clk, resetn  clock; asynchronous active-low reset
//   inst_sram    instruction requester (slave side of the channel)
//   data_sram    data requester (slave side of the channel)
//   sram         shared downstream channel (master side)
//   err_unexp    sticky: a response arrived with nothing outstanding
module sram_arbiter #(
    parameter int unsigned OT_DEPTH = 4
) (
    input  logic           clk,
    input  logic           resetn,
    sram_arbiter_if.slave  inst_sram,
    sram_arbiter_if.slave  data_sram,
    sram_arbiter_if.master sram,
    output logic           err_unexp
);
    localparam int unsigned PtrW = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(OT_DEPTH);

    typedef enum logic [1:0] {StFree, StLockI, StLockD} state_e;

    state_e            state_q, state_d;
    logic              grant_data;
    logic              gnt_req;
    logic              ot_full;
    logic              ot_empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic              head;
    logic [OT_DEPTH-1:0] owner_q;
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CntW-1:0]   count_q;
    logic              err_q;

    // Grant selection: data wins when free; a locked grant ignores the other side.
    always_comb begin
        grant_data = data_sram.req;
        unique case (state_q)
            StLockI: grant_data = 1'b0;
            StLockD: grant_data = 1'b1;
            default: grant_data = data_sram.req;
        endcase
    end

    assign gnt_req  = grant_data ? data_sram.req : inst_sram.req;
    assign ot_full  = (count_q == CntFull);
    assign ot_empty = (count_q == '0);

    // Downstream request is a pure mux of the granted requester.
    assign sram.req   = gnt_req & ~ot_full;
    assign sram.wr    = grant_data ? data_sram.wr    : inst_sram.wr;
    assign sram.size  = grant_data ? data_sram.size  : inst_sram.size;
    assign sram.wstrb = grant_data ? data_sram.wstrb : inst_sram.wstrb;
    assign sram.addr  = grant_data ? data_sram.addr  : inst_sram.addr;
    assign sram.wdata = grant_data ? data_sram.wdata : inst_sram.wdata;

    assign accept            = sram.req & sram.addr_ok;
    assign inst_sram.addr_ok = accept & ~grant_data;
    assign data_sram.addr_ok = accept &  grant_data;

    // Responses return in acceptance order; the FIFO head names the owner.
    assign push = accept;
    assign pop  = sram.data_ok & ~ot_empty;
    assign head = owner_q[rptr_q];

    assign inst_sram.data_ok = pop & ~head;
    assign data_sram.data_ok = pop &  head;
    assign inst_sram.rdata   = sram.rdata;
    assign data_sram.rdata   = sram.rdata;
    assign err_unexp         = err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFree: begin
                if (sram.req && !sram.addr_ok) begin
                    state_d = grant_data ? StLockD : StLockI;
                end
            end
            StLockI: if (accept || !inst_sram.req) state_d = StFree;
            StLockD: if (accept || !data_sram.req) state_d = StFree;
            default: state_d = StFree;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StFree;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointers wrap naturally because OT_DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                owner_q[wptr_q] <= grant_data;
                wptr_q          <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            if (sram.data_ok && ot_empty) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: inputs driven 1 time unit after posedge,
// outputs sampled at negedge; expected response owners kept in a scoreboard queue.
module tb_sram_arbiter;
    localparam int unsigned OT_DEPTH = 4;

    logic clk = 1'b0;
    logic resetn;
    logic err_unexp;
    int   vectors = 0;
    int   miscompares = 0;
    bit   exp_owner_q[$];   // 0 = inst, 1 = data

    always #5 clk = ~clk;

    sram_arbiter_if inst_if ();
    sram_arbiter_if data_if ();
    sram_arbiter_if mem_if ();

    sram_arbiter #(.OT_DEPTH(OT_DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .inst_sram (inst_if),
        .data_sram (data_if),
        .sram      (mem_if),
        .err_unexp (err_unexp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_if.req = 0; inst_if.wr = 0; inst_if.size = 0; inst_if.wstrb = 0;
        inst_if.addr = 0; inst_if.wdata = 0;
        data_if.req = 0; data_if.wr = 0; data_if.size = 0; data_if.wstrb = 0;
        data_if.addr = 0; data_if.wdata = 0;
        mem_if.addr_ok = 0; mem_if.data_ok = 0; mem_if.rdata = 0;
    endtask

    // Drive one downstream response, pop the expected owner and compare.
    task automatic drive_response(input logic [31:0] rd);
        bit owner;
        mem_if.data_ok = 1'b1;
        mem_if.rdata   = rd;
        @(negedge clk);
        vectors++;
        if (exp_owner_q.size() == 0) begin
            miscompares++;
            $display("FAIL resp_underflow: response %h with empty scoreboard", rd);
        end else begin
            owner = exp_owner_q.pop_front();
            if ({data_if.data_ok, inst_if.data_ok} !== {owner, ~owner}) begin
                miscompares++;
                $display("FAIL resp_route: got d/i data_ok=%b%b want %b%b",
                         data_if.data_ok, inst_if.data_ok, owner, ~owner);
            end
        end
        vectors++;
        if (inst_if.rdata !== rd || data_if.rdata !== rd) begin
            miscompares++;
            $display("FAIL resp_rdata: got i=%h d=%h want %h", inst_if.rdata, data_if.rdata, rd);
        end
        step();
        mem_if.data_ok = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        data_if.req = 1; data_if.addr = 32'h2000_0010;
        inst_if.req = 1; inst_if.addr = 32'h1C00_0000;
        #3;
        vectors++;
        if (mem_if.req !== 1'b1 || mem_if.addr !== 32'h2000_0010) begin
            miscompares++;
            $display("FAIL reset_req: got req=%b addr=%h want 1 20000010", mem_if.req, mem_if.addr);
        end
        vectors++;
        if ({inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_handshake: got %b%b%b%b want 0000", inst_if.addr_ok,
                     data_if.addr_ok, inst_if.data_ok, data_if.data_ok);
        end
        vectors++;
        if (err_unexp !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got %b want 0", err_unexp);
        end
        idle();
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_priority();
        data_if.req = 1; data_if.wr = 1; data_if.size = 2; data_if.wstrb = 4'hF;
        data_if.addr = 32'h2000_0100; data_if.wdata = 32'hDEAD_BEEF;
        inst_if.req = 1; inst_if.wr = 0; inst_if.size = 1; inst_if.wstrb = 4'h0;
        inst_if.addr = 32'h1C00_0004; inst_if.wdata = 32'h0000_1234;
        mem_if.addr_ok = 1;
        @(negedge clk);
        vectors++;
        if (mem_if.addr !== 32'h2000_0100 || mem_if.wdata !== 32'hDEAD_BEEF
            || mem_if.wr !== 1'b1 || mem_if.wstrb !== 4'hF || mem_if.size !== 2'd2) begin
            miscompares++;
            $display("FAIL prio_mux: got addr=%h wdata=%h wr=%b wstrb=%h want data fields",
                     mem_if.addr, mem_if.wdata, mem_if.wr, mem_if.wstrb);
        end
        vectors++;
        if (data_if.addr_ok !== 1'b1 || inst_if.addr_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_addr_ok: got d=%b i=%b want d=1 i=0",
                     data_if.addr_ok, inst_if.addr_ok);
        end
        exp_owner_q.push_back(1'b1);
        step();
        idle();
        drive_response(32'h5555_AAAA);
    endtask

    task automatic test_lock();
        inst_if.req = 1; inst_if.addr = 32'h1C00_0000;
        mem_if.addr_ok = 0;
        @(negedge clk);
        vectors++;
        if (mem_if.addr !== 32'h1C00_0000 || inst_if.addr_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_c0: got addr=%h addr_ok=%b want 1c000000 0",
                     mem_if.addr, inst_if.addr_ok);
        end
        step();
        data_if.req = 1; data_if.addr = 32'h2000_0200;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (mem_if.addr !== 32'h1C00_0000 || data_if.addr_ok !== 1'b0) begin
                miscompares++;
                $display("FAIL lock_hold c%0d: got addr=%h d_addr_ok=%b want 1c000000 0",
                         c, mem_if.addr, data_if.addr_ok);
            end
            step();
        end
        mem_if.addr_ok = 1;
        @(negedge clk);
        vectors++;
        if (mem_if.addr !== 32'h1C00_0000 || inst_if.addr_ok !== 1'b1
            || data_if.addr_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_accept: got addr=%h i=%b d=%b want 1c000000 1 0",
                     mem_if.addr, inst_if.addr_ok, data_if.addr_ok);
        end
        exp_owner_q.push_back(1'b0);
        step();
        inst_if.req = 0;
        @(negedge clk);
        vectors++;
        if (mem_if.addr !== 32'h2000_0200 || data_if.addr_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_next: got addr=%h d_addr_ok=%b want 20000200 1",
                     mem_if.addr, data_if.addr_ok);
        end
        exp_owner_q.push_back(1'b1);
        step();
        idle();
        drive_response(32'h0BAD_0001);
        drive_response(32'h0BAD_0002);
    endtask

    task automatic test_order();
        bit seq[3] = '{1'b0, 1'b1, 1'b0};
        mem_if.addr_ok = 1;
        for (int k = 0; k < 3; k++) begin
            inst_if.req = !seq[k]; inst_if.addr = 32'h1C00_0100 + k;
            data_if.req = seq[k];  data_if.addr = 32'h2000_0300 + k;
            @(negedge clk);
            vectors++;
            if ({data_if.addr_ok, inst_if.addr_ok} !== {seq[k], ~seq[k]}) begin
                miscompares++;
                $display("FAIL order_accept%0d: got d/i=%b%b want %b%b", k,
                         data_if.addr_ok, inst_if.addr_ok, seq[k], ~seq[k]);
            end
            exp_owner_q.push_back(seq[k]);
            step();
        end
        idle();
        drive_response(32'h0000_0011);
        drive_response(32'h0000_0022);
        drive_response(32'h0000_0033);
    endtask

    task automatic test_full();
        bit owner;
        inst_if.req = 1; inst_if.addr = 32'h1C00_0400;
        mem_if.addr_ok = 1;
        for (int k = 0; k < OT_DEPTH; k++) begin
            @(negedge clk);
            vectors++;
            if (inst_if.addr_ok !== 1'b1) begin
                miscompares++;
                $display("FAIL full_fill%0d: got addr_ok=%b want 1", k, inst_if.addr_ok);
            end
            exp_owner_q.push_back(1'b0);
            step();
        end
        @(negedge clk);
        vectors++;
        if (mem_if.req !== 1'b0 || inst_if.addr_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL full_block: got req=%b addr_ok=%b want 0 0",
                     mem_if.req, inst_if.addr_ok);
        end
        step();
        // Pop while full: the slot only frees on the next cycle.
        mem_if.data_ok = 1; mem_if.rdata = 32'h0000_00A0;
        @(negedge clk);
        owner = exp_owner_q.pop_front();
        vectors++;
        if (mem_if.req !== 1'b0 || inst_if.data_ok !== ~owner) begin
            miscompares++;
            $display("FAIL full_pop: got req=%b i_data_ok=%b want 0 1",
                     mem_if.req, inst_if.data_ok);
        end
        step();
        // Push and pop in the same cycle keep the count unchanged.
        mem_if.rdata = 32'h0000_00A1;
        @(negedge clk);
        owner = exp_owner_q.pop_front();
        vectors++;
        if (mem_if.req !== 1'b1 || inst_if.addr_ok !== 1'b1 || inst_if.data_ok !== ~owner) begin
            miscompares++;
            $display("FAIL full_pushpop: got req=%b addr_ok=%b data_ok=%b want 1 1 1",
                     mem_if.req, inst_if.addr_ok, inst_if.data_ok);
        end
        exp_owner_q.push_back(1'b0);
        step();
        mem_if.data_ok = 0;
        @(negedge clk);
        vectors++;
        if (mem_if.req !== 1'b1 || inst_if.addr_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL full_refill: got req=%b addr_ok=%b want 1 1",
                     mem_if.req, inst_if.addr_ok);
        end
        exp_owner_q.push_back(1'b0);
        step();
        @(negedge clk);
        vectors++;
        if (mem_if.req !== 1'b0) begin
            miscompares++;
            $display("FAIL full_again: got req=%b want 0", mem_if.req);
        end
        step();
        idle();
        for (int k = 0; k < OT_DEPTH; k++) drive_response(32'h0000_00B0 + k);
    endtask

    task automatic test_unexp();
        idle();
        vectors++;
        if (err_unexp !== 1'b0) begin
            miscompares++;
            $display("FAIL unexp_pre: got %b want 0", err_unexp);
        end
        mem_if.data_ok = 1; mem_if.rdata = 32'h0000_0077;
        @(negedge clk);
        vectors++;
        if (inst_if.data_ok !== 1'b0 || data_if.data_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL unexp_route: got i=%b d=%b want 0 0",
                     inst_if.data_ok, data_if.data_ok);
        end
        step();
        mem_if.data_ok = 0;
        @(negedge clk);
        vectors++;
        if (err_unexp !== 1'b1) begin
            miscompares++;
            $display("FAIL unexp_set: got %b want 1", err_unexp);
        end
        repeat (3) step();
        @(negedge clk);
        vectors++;
        if (err_unexp !== 1'b1) begin
            miscompares++;
            $display("FAIL unexp_sticky: got %b want 1", err_unexp);
        end
        step();
        resetn = 1'b0;
        #1;
        vectors++;
        if (err_unexp !== 1'b0) begin
            miscompares++;
            $display("FAIL unexp_clear: got %b want 0", err_unexp);
        end
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        mem_if.addr_ok = 1;
        inst_if.req = 1; inst_if.addr = 32'h1C00_0800;
        repeat (2) begin
            @(negedge clk);
            exp_owner_q.push_back(1'b0);
            step();
        end
        inst_if.req = 0;
        data_if.req = 1; data_if.addr = 32'h2000_0800;
        mem_if.addr_ok = 0;
        step();                 // now LOCK_D with two outstanding
        data_if.req = 0;
        inst_if.req = 1;
        mem_if.data_ok = 1; mem_if.rdata = 32'h0000_0099;
        #1;
        vectors++;
        if (mem_if.req !== 1'b0 || inst_if.data_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_pre: got req=%b i_data_ok=%b want 0 1",
                     mem_if.req, inst_if.data_ok);
        end
        resetn = 1'b0;
        #1;
        vectors++;
        if (mem_if.req !== 1'b1 || mem_if.addr !== 32'h1C00_0800) begin
            miscompares++;
            $display("FAIL arst_state: got req=%b addr=%h want 1 1c000800",
                     mem_if.req, mem_if.addr);
        end
        vectors++;
        if (inst_if.data_ok !== 1'b0 || data_if.data_ok !== 1'b0 || err_unexp !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_count: got i=%b d=%b err=%b want 0 0 0",
                     inst_if.data_ok, data_if.data_ok, err_unexp);
        end
        exp_owner_q.delete();
        idle();
        step();
        resetn = 1'b1;
        step();
        mem_if.data_ok = 1;
        step();
        mem_if.data_ok = 0;
        @(negedge clk);
        vectors++;
        if (err_unexp !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_stray: got %b want 1", err_unexp);
        end
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        #1;
        test_reset();
        test_priority();
        test_lock();
        test_order();
        test_full();
        test_unexp();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: OT_DEPTH, default 4, maximum outstanding accepted-but-unanswered transactions; power of two, 2..8.
REQ-002 clk  in  1  core clock; all state updates on posedge clk.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 inst_sram_req/wr  in  1/1  instruction requester request, write flag.
REQ-005 inst_sram_size/wstrb  in  2/4  access size, byte strobes.
REQ-006 inst_sram_addr/wdata  in  32/32  address, write data.
REQ-007 inst_sram_addr_ok/data_ok  out  1/1  request accepted; response returned, to instruction requester.
REQ-008 inst_sram_rdata  out  32  read data to instruction requester.
REQ-009 data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  data requester, same meaning as REQ-004..006.
REQ-010 data_sram_addr_ok/data_ok/rdata  out  1/1/32  data requester handshake and read data.
REQ-011 sram_req/wr/size/wstrb/addr/wdata  out  1/1/2/4/32/32  shared downstream request channel.
REQ-012 sram_addr_ok/data_ok  in  1/1  downstream accept and response; responses in acceptance order.
REQ-013 sram_rdata  in  32  downstream read data.
REQ-014 err_unexp  out  1  sticky: data_ok received while nothing outstanding.

Function
REQ-015 Downstream request fields (wr,size,wstrb,addr,wdata) SHALL be a pure mux of the granted requester's fields; sram_req = granted requester's req & ~ot_full.
REQ-016 Grant state machine, states FREE, LOCK_I, LOCK_D; reset state FREE.
REQ-017 FREE: grant data if data_sram_req, else inst if inst_sram_req (data has fixed priority).
REQ-018 FREE -> LOCK_x at posedge when sram_req=1 and sram_addr_ok=0 (x = current grantee); grant SHALL then stay x regardless of other requests.
REQ-019 LOCK_x -> FREE at posedge when sram_addr_ok=1 & sram_req=1; LOCK_x -> FREE also if requester x drops req (cancelled before accept).
REQ-020 Accept = sram_req & sram_addr_ok; <x>_sram_addr_ok = accept & grant==x; non-granted addr_ok SHALL be 0.
REQ-021 Owner FIFO, OT_DEPTH entries of 1 bit (0=inst,1=data); push owner on accept; pop on sram_data_ok when not empty.
REQ-022 ot_full = count==OT_DEPTH; while full, sram_req=0 and no addr_ok to either requester.
REQ-023 Same-cycle push and pop SHALL leave count unchanged and be legal at full (pop frees slot only next cycle; REQ-022 uses registered count) and at empty is not applicable (pop needs non-empty).
REQ-024 <x>_sram_data_ok = sram_data_ok & ~empty & head==x, combinational, zero-cycle latency.
REQ-025 inst_sram_rdata and data_sram_rdata SHALL both equal sram_rdata unconditionally.
REQ-026 sram_data_ok while empty: no data_ok to either requester, no pop, err_unexp set to 1 until reset.
REQ-027 Read and write pointers SHALL wrap modulo OT_DEPTH; count width clog2(OT_DEPTH)+1.
REQ-028 Arbiter adds no latency on request path: a requester granted in FREE with sram_addr_ok=1 is accepted in that same cycle.

Reset
REQ-029 resetn low asynchronously: state FREE, FIFO pointers and count 0, err_unexp 0; outputs then: sram_req = data_sram_req|inst_sram_req gated per REQ-015, all addr_ok/data_ok 0 unless downstream asserts.
REQ-030 Reset mid-operation discards all outstanding owner records; subsequent stray sram_data_ok SHALL set err_unexp.

Verification
REQ-031 Both req=1 in FREE, sram_addr_ok=1 -> sram_addr=data_sram_addr, data_sram_addr_ok=1, inst_sram_addr_ok=0, FIFO head=1.
REQ-032 inst req (addr 0x1C000000), sram_addr_ok=0 for 3 cycles, data req arrives cycle 1 -> sram_addr stays 0x1C000000 until accept; data granted the cycle after.
REQ-033 Accept I,D,I then sram_data_ok on 3 consecutive cycles with rdata 0x11,0x22,0x33 -> inst gets 0x11, data 0x22, inst 0x33; count returns 0.
REQ-034 OT_DEPTH=4, four accepts without response -> sram_req=0 with req held; one data_ok -> sram_req=1 next cycle.
REQ-035 sram_data_ok pulse with count 0 -> no requester data_ok, err_unexp=1 and stays 1 until resetn low.
REQ-036 resetn low asynchronously with count 2 in LOCK_D -> state FREE, count 0 immediately, before next clk edge.
